// File: rtl/inst_encoder.sv
// inst_encoder: packs decoded RV32 instruction fields back into a 32-bit word through a 2-entry FIFO.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   in_valid/in_ready               field bundle handshake
//   in_opcode/in_funct3/in_funct7b5 opcode, funct3 and bit 30 of the instruction
//   in_rd/in_rs1/in_rs2             register indices
//   in_imm                          sign-extended immediate
//   pc_clear                        synchronous restart of the issue address at PC_BASE
//   out_valid/out_ready             encoded word handshake
//   out_inst/out_pc/out_err         encoded word, its issue address, unencodable flag
// Build option: define IMM_RANGE_CHECK_EN to flag immediates that do not fit their format.
module inst_encoder #(
  parameter int          WORD_BITWIDTH    = 32,
  parameter int          REG_NUM_BITWIDTH = 5,
  parameter logic [31:0] PC_BASE          = 32'h0,
  parameter logic [6:0]  INST_R           = 7'b0110011,
  parameter logic [6:0]  INST_I_LD        = 7'b0000011,
  parameter logic [6:0]  INST_I_IMM       = 7'b0010011,
  parameter logic [6:0]  INST_S           = 7'b0100011,
  parameter logic [6:0]  INST_B           = 7'b1100011,
  parameter logic [6:0]  INST_J           = 7'b1101111
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [6:0]                  in_opcode,
  input  logic [2:0]                  in_funct3,
  input  logic                        in_funct7b5,
  input  logic [REG_NUM_BITWIDTH-1:0] in_rd,
  input  logic [REG_NUM_BITWIDTH-1:0] in_rs1,
  input  logic [REG_NUM_BITWIDTH-1:0] in_rs2,
  input  logic [WORD_BITWIDTH-1:0]    in_imm,
  input  logic                        pc_clear,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WORD_BITWIDTH-1:0]    out_inst,
  output logic [31:0]                 out_pc,
  output logic                        out_err
);
  localparam logic [WORD_BITWIDTH-1:0] NOP = 32'h00000013;
  logic [WORD_BITWIDTH-1:0] w_inst;
  logic                     w_err;
  logic                     w_bad_i, w_bad_b, w_bad_j;
  logic                     w_push, w_pop;
  logic [WORD_BITWIDTH:0]   w_head;
  logic [WORD_BITWIDTH:0]   r_mem [2];
  logic                     r_wr_ptr, r_rd_ptr, r_live;
  logic [1:0]               r_count;
  logic [31:0]              r_pc;
`ifdef IMM_RANGE_CHECK_EN
  // An immediate fits N signed bits when every bit above N-2 equals the sign bit.
  assign w_bad_i = !(&in_imm[31:11] | ~|in_imm[31:11]);
  assign w_bad_b = !(&in_imm[31:12] | ~|in_imm[31:12]) | in_imm[0];
  assign w_bad_j = !(&in_imm[31:20] | ~|in_imm[31:20]) | in_imm[0];
`else
  assign w_bad_i = 1'b0;
  assign w_bad_b = 1'b0;
  assign w_bad_j = 1'b0;
`endif
  always_comb begin
    w_inst = NOP;
    w_err  = 1'b1;
    case (in_opcode)
      INST_R: begin
        w_inst = {1'b0, in_funct7b5, 5'b0, in_rs2, in_rs1, in_funct3, in_rd, in_opcode};
        w_err  = 1'b0;
      end
      INST_I_LD, INST_I_IMM: begin
        w_inst = {in_imm[11:0], in_rs1, in_funct3, in_rd, in_opcode};
        // Shift-immediates carry the SRAI select in bit 30 instead of upper immediate bits.
        if (in_opcode == INST_I_IMM && in_funct3[1:0] == 2'b01) w_inst[31:25] = {1'b0, in_funct7b5, 5'b0};
        w_err  = w_bad_i;
      end
      INST_S: begin
        w_inst = {in_imm[11:5], in_rs2, in_rs1, in_funct3, in_imm[4:0], in_opcode};
        w_err  = w_bad_i;
      end
      INST_B: begin
        w_inst = {in_imm[12], in_imm[10:5], in_rs2, in_rs1, in_funct3, in_imm[4:1], in_imm[11], in_opcode};
        w_err  = w_bad_b;
      end
      INST_J: begin
        w_inst = {in_imm[20], in_imm[10:1], in_imm[11], in_imm[19:12], in_rd, in_opcode};
        w_err  = w_bad_j;
      end
      default: begin
        w_inst = NOP;
        w_err  = 1'b1;
      end
    endcase
  end
  // r_live keeps in_ready low until the first edge after reset release.
  assign in_ready  = r_live && r_count != 2'd2;
  assign out_valid = r_count != 2'd0;
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign w_head    = r_mem[r_rd_ptr];
  assign out_inst  = out_valid ? w_head[WORD_BITWIDTH-1:0] : NOP;
  assign out_err   = out_valid && w_head[WORD_BITWIDTH];
  assign out_pc    = r_pc;
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= {w_err, w_inst};
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_live   <= 1'b0;
      r_count  <= 2'd0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_pc     <= PC_BASE;
    end else begin
      r_live   <= 1'b1;
      r_wr_ptr <= r_wr_ptr ^ w_push;
      r_rd_ptr <= r_rd_ptr ^ w_pop;
      r_count  <= r_count + {1'b0, w_push} - {1'b0, w_pop};
      r_pc     <= pc_clear ? PC_BASE : w_pop ? r_pc + 32'd4 : r_pc;
    end
  end
endmodule

// File: tb/tb_inst_encoder.sv
// tb_inst_encoder: scoreboard bench for inst_encoder.
module tb_inst_encoder;
  logic        clk = 1'b0, rst_n = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [6:0]  in_opcode = '0;
  logic [2:0]  in_funct3 = '0;
  logic        in_funct7b5 = 1'b0;
  logic [4:0]  in_rd = '0, in_rs1 = '0, in_rs2 = '0;
  logic [31:0] in_imm = '0;
  logic        pc_clear = 1'b0;
  logic        out_valid, out_ready = 1'b0, out_err;
  logic [31:0] out_inst, out_pc;
  int          n_cmp = 0, n_bad = 0;
  logic [32:0] sb [$];
  logic [31:0] exp_pc = 32'h0;
  logic [6:0]  ops [7] = '{7'h33, 7'h03, 7'h13, 7'h23, 7'h63, 7'h6f, 7'h37};
`ifdef IMM_RANGE_CHECK_EN
  localparam bit RC = 1'b1;
`else
  localparam bit RC = 1'b0;
`endif

  inst_encoder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_funct3(in_funct3), .in_funct7b5(in_funct7b5),
    .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_imm(in_imm),
    .pc_clear(pc_clear), .out_valid(out_valid), .out_ready(out_ready),
    .out_inst(out_inst), .out_pc(out_pc), .out_err(out_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [32:0] model(input logic [6:0] op, input logic [2:0] f3, input logic f7,
                                        input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic [31:0] imm);
    logic [31:0] w;
    logic        rng, ill;
    int          s;
    s = $signed(imm);
    rng = 1'b0;
    ill = 1'b0;
    case (op)
      7'h33: w = {1'b0, f7, 5'b0, rs2, rs1, f3, rd, op};
      7'h03, 7'h13: begin
        w = {imm[11:0], rs1, f3, rd, op};
        if (op == 7'h13 && (f3 == 3'b001 || f3 == 3'b101)) w[31:25] = {1'b0, f7, 5'b0};
        rng = s < -2048 || s > 2047;
      end
      7'h23: begin
        w = {imm[11:5], rs2, rs1, f3, imm[4:0], op};
        rng = s < -2048 || s > 2047;
      end
      7'h63: begin
        w = {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], op};
        rng = s < -4096 || s > 4095 || imm[0];
      end
      7'h6f: begin
        w = {imm[20], imm[10:1], imm[11], imm[19:12], rd, op};
        rng = s < -1048576 || s > 1048575 || imm[0];
      end
      default: begin
        w = 32'h00000013;
        ill = 1'b1;
      end
    endcase
    return {ill | (RC & rng), w};
  endfunction

  // Drives one bundle, waits (bounded) for acceptance, and records the expectation.
  task automatic send(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [4:0] rd,
                      input logic [4:0] rs1, input logic [4:0] rs2, input logic [31:0] imm,
                      input logic [32:0] exp, input bit rnd);
    int t = 0;
    in_opcode = op; in_funct3 = f3; in_funct7b5 = f7;
    in_rd = rd; in_rs1 = rs1; in_rs2 = rs2; in_imm = imm;
    in_valid = 1'b1;
    if (rnd) out_ready = 1'($urandom_range(0, 1));
    while (!in_ready && t < 50) begin
      @(posedge clk); #1;
      if (rnd) out_ready = 1'($urandom_range(0, 1));
      t++;
    end
    if (!in_ready) chk("accept_timeout", 0, 1);
    else sb.push_back(exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && t < 50) begin
      @(posedge clk); #1;
      t++;
    end
    chk("drain", 64'(sb.size()), 0);
  endtask

  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (sb.size() == 0) chk("spurious_out", {32'h0, out_inst}, 64'hFFFFFFFF_FFFFFFFF);
      else begin
        logic [32:0] e;
        e = sb.pop_front();
        chk("inst", out_inst, e[31:0]);
        chk("err", out_err, e[32]);
        chk("pc", out_pc, exp_pc);
      end
      exp_pc += 32'd4;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    chk("rst_valid", out_valid, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_inst", out_inst, 32'h13);
    chk("rst_err", out_err, 0);
    chk("rst_pc", out_pc, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("pre_edge_ready", in_ready, 0);
    @(posedge clk); #1;
    chk("post_rst_ready", in_ready, 1);
    // addi x1,x0,5 and one-cycle latency
    out_ready = 1'b1;
    send(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, {1'b0, 32'h00500093}, 1'b0);
    chk("lat_valid", out_valid, 1);
    chk("lat_inst", out_inst, 32'h00500093);
    chk("lat_pc", out_pc, 0);
    // add / sub back-to-back, then beq with negative offset
    send(7'h33, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h002081B3}, 1'b0);
    send(7'h33, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0, {1'b0, 32'h402081B3}, 1'b0);
    send(7'h63, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFFC, {1'b0, 32'hFE208EE3}, 1'b0);
    // illegal opcode and out-of-range addi
    send(7'h37, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, {1'b1, 32'h00000013}, 1'b0);
    send(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, {RC, 32'h80000093}, 1'b0);
    // srai x5,x6,3 / sw x2,-8(x1) / jal x1,+2048
    send(7'h13, 3'd5, 1'b1, 5'd5, 5'd6, 5'd0, 32'd3, {1'b0, 32'h40335293}, 1'b0);
    send(7'h23, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'hFFFFFFF8, {1'b0, 32'hFE20AC23}, 1'b0);
    send(7'h6f, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, {1'b0, 32'h001000EF}, 1'b0);
    drain();
    // random bundles under random backpressure
    for (int i = 0; i < 40; i++) begin
      logic [6:0] op; logic [2:0] f3; logic f7; logic [4:0] rd, r1, r2; logic [31:0] imm;
      op = ops[$urandom_range(0, 6)];
      f3 = 3'($urandom); f7 = 1'($urandom);
      rd = 5'($urandom); r1 = 5'($urandom); r2 = 5'($urandom);
      imm = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4095)) - 32'd2048;
      send(op, f3, f7, rd, r1, r2, imm, model(op, f3, f7, rd, r1, r2, imm), 1'b1);
    end
    drain();
    // full FIFO: third bundle waits for the first pop, head holds meanwhile
    out_ready = 1'b0;
    send(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, {1'b0, 32'h00100093}, 1'b0);
    send(7'h13, 3'd0, 1'b0, 5'd2, 5'd0, 5'd0, 32'd2, {1'b0, 32'h00200113}, 1'b0);
    chk("full_ready", in_ready, 0);
    repeat (3) @(posedge clk);
    #1;
    chk("hold_valid", out_valid, 1);
    chk("hold_inst", out_inst, 32'h00100093);
    chk("hold_pc", out_pc, exp_pc);
    out_ready = 1'b1;
    send(7'h13, 3'd0, 1'b0, 5'd3, 5'd0, 5'd0, 32'd3, {1'b0, 32'h00300193}, 1'b0);
    drain();
    // pc_clear wins over a same-cycle pop
    send(7'h33, 3'd7, 1'b0, 5'd4, 5'd5, 5'd6, 32'd0, {1'b0, 32'h0062F233}, 1'b0);
    pc_clear = 1'b1;
    @(posedge clk); #1;
    pc_clear = 1'b0;
    exp_pc = 32'h0;
    chk("clr_pc", out_pc, 0);
    // pc_clear leaves queued entries intact
    out_ready = 1'b0;
    send(7'h03, 3'd2, 1'b0, 5'd7, 5'd8, 5'd0, 32'd16, {1'b0, 32'h01042383}, 1'b0);
    pc_clear = 1'b1;
    @(posedge clk); #1;
    pc_clear = 1'b0;
    exp_pc = 32'h0;
    chk("clr_keep_valid", out_valid, 1);
    chk("clr_keep_pc", out_pc, 0);
    drain();
    // asynchronous reset with two entries queued
    out_ready = 1'b0;
    send(7'h13, 3'd0, 1'b0, 5'd9, 5'd0, 5'd0, 32'd9, {1'b0, 32'h00900493}, 1'b0);
    send(7'h13, 3'd0, 1'b0, 5'd10, 5'd0, 5'd0, 32'd10, {1'b0, 32'h00A00513}, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 0);
    chk("mid_rst_pc", out_pc, 0);
    chk("mid_rst_inst", out_inst, 32'h13);
    sb.delete();
    exp_pc = 32'h0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("rel_ready", in_ready, 1);
    chk("rel_valid", out_valid, 0);
    out_ready = 1'b1;
    send(7'h13, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, {1'b0, 32'h00500093}, 1'b0);
    drain();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/inst_encoder.md
INST_ENCODER -- requirements
Module: inst_encoder

Interface
REQ-001 SHALL have parameters: WORD_BITWIDTH, default 32, instruction word width; REG_NUM_BITWIDTH, default 5, register index width; PC_BASE, default 32'h0, first issue address.
REQ-002 SHALL have opcode parameters INST_R=7'b0110011, INST_I_LD=7'b0000011, INST_I_IMM=7'b0010011, INST_S=7'b0100011, INST_B=7'b1100011, INST_J=7'b1101111.
REQ-003 SHALL have ports, clock and reset first:
- clk  in  1  sole clock; all state changes on its rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept a bundle.
- in_opcode  in  7  instruction bits [6:0].
- in_funct3  in  3  instruction bits [14:12].
- in_funct7b5  in  1  instruction bit 30 (SUB/SRA/SRAI select).
- in_rd, in_rs1, in_rs2  in  5 each  register indices.
- in_imm  in  32  sign-extended immediate as the decoder presents it.
- pc_clear  in  1  synchronous restart of issue address at PC_BASE.
- out_valid  out  1  encoded word available.
- out_ready  in  1  consumer accepts the word.
- out_inst  out  32  encoded instruction word.
- out_pc  out  32  issue address of out_inst.
- out_err  out  1  entry flagged as unencodable.

Function
REQ-004 SHALL accept a bundle on a cycle with in_valid && in_ready and SHALL encode it combinationally into a 2-entry FIFO of {inst, err}.
REQ-005 SHALL drive in_ready = (FIFO count < 2); a full FIFO SHALL NOT accept, even when a pop occurs in the same cycle.
REQ-006 SHALL drive out_valid = (count != 0), with out_inst/out_err taken from the FIFO head; accept-to-out_valid latency SHALL be exactly 1 cycle.
REQ-007 SHALL pop on out_valid && out_ready; simultaneous push and pop with count 1 SHALL leave count at 1, in order.
REQ-008 SHALL hold out_inst, out_pc and out_err stable while out_valid && !out_ready.
REQ-009 SHALL encode R as {1'b0, in_funct7b5, 5'b0, rs2, rs1, funct3, rd, opcode}.
REQ-010 SHALL encode I_LD/I_IMM as {imm[11:0], rs1, funct3, rd, opcode}; for I_IMM with funct3 = 3'b001 or 3'b101, bits [31:25] SHALL be {1'b0, in_funct7b5, 5'b0}.
REQ-011 SHALL encode S as {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}.
REQ-012 SHALL encode B as {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode}.
REQ-013 SHALL encode J as {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode}.
REQ-014 SHALL encode any other opcode as 32'h00000013 (NOP) with err = 1.
REQ-015 SHALL hold a 32-bit issue counter: out_pc = counter; +4 on each pop, wrapping modulo 2^32.
REQ-016 SHALL give pc_clear priority over a same-cycle pop increment, loading PC_BASE; FIFO contents SHALL be unaffected.

Reset
REQ-017 SHALL, on rst_n low, immediately empty the FIFO and set out_valid=0, in_ready=0, out_inst=32'h00000013, out_err=0, out_pc=PC_BASE.
REQ-018 SHALL drive in_ready=1 from the first clock edge after rst_n deasserts; bundles pending when reset asserts mid-operation SHALL be discarded.

Configuration
REQ-019 SHALL, with IMM_RANGE_CHECK_EN defined, set err = 1 when in_imm does not fit the format: I/S not a 12-bit signed value; B not a 13-bit signed value or imm[0]=1; J not a 21-bit signed value or imm[0]=1; the word SHALL still be encoded from the truncated bits.
REQ-020 SHALL, without IMM_RANGE_CHECK_EN, set err only per REQ-014 and omit the range-check logic.

Verification
REQ-021 addi x1,x0,5 (op 0x13, f3 0, rd 1, rs1 0, imm 5), out_ready=1 -> next cycle out_inst=0x00500093, out_pc=0, err=0.
REQ-022 add then sub x3,x1,x2 back-to-back -> 0x002081B3 at pc 0, then 0x402081B3 at pc 4.
REQ-023 beq x1,x2 with imm=0xFFFFFFFC -> out_inst=0xFE208EE3, err=0.
REQ-024 out_ready=0, three consecutive valid bundles -> in_ready=0 after two accepts; third accepted only after the first pop; order and pc preserved.
REQ-025 opcode 0x37 -> 0x00000013, err=1; addi imm=2048 -> bits[31:20]=0x800, err=1 with IMM_RANGE_CHECK_EN, err=0 without.
REQ-026 rst_n low with two entries queued -> out_valid=0 immediately; after release pc=PC_BASE, no stale word emitted.
